// File: rtl/core_pkg.sv
// Shared definitions for the RV32I subset core: opcodes, ALU codes, FSM states
// and datapath mux encodings.
package core_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Codes 0..3 keep the values used by the single-cycle decoder.
    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_XOR = 2;
    localparam int unsigned ALU_SLL = 3;
    localparam int unsigned ALU_SRL = 4;
    localparam int unsigned ALU_AND = 5;
    localparam int unsigned ALU_OR  = 6;
    localparam int unsigned ALU_SLT = 7;

    localparam int unsigned WB_ALUOUT = 0;
    localparam int unsigned WB_MDR    = 1;
    localparam int unsigned WB_PC     = 2;

    localparam int unsigned SRCA_PC    = 0;
    localparam int unsigned SRCA_RS1   = 1;
    localparam int unsigned SRCA_OLDPC = 2;
    localparam int unsigned SRCA_ZERO  = 3;

    localparam int unsigned SRCB_RS2  = 0;
    localparam int unsigned SRCB_FOUR = 1;
    localparam int unsigned SRCB_IMM  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Access-complete detection for memory states: either the ready handshake or
// a fixed latency counted from entry into the memory state.
module mem_wait_timer #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_LAT       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_state,
    input  logic mem_ready,
    output logic done
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] cnt;

    assign done = mem_state &&
                  (MEM_HANDSHAKE ? mem_ready : (cnt == CNT_W'(MEM_LAT - 1)));

    // Clearing on completion also covers MEM_WR -> FETCH, a memory-to-memory hop.
    always_ff @(posedge clk) begin
        if (rst || !mem_state || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I subset core: sequences fetch, decode,
// execute, memory and writeback on a shared-ALU, single-memory datapath.
module multicycle_control
    import core_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_LAT       = 1,
    parameter int unsigned ALUCTRL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 pc_source,
    output logic                 instr_done,
    output logic                 trap,
    output logic [3:0]           state_o
);

    state_t state, state_next;
    logic   access_done;
    logic   r_legal;
    logic [ALUCTRL_W-1:0] r_alu;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_b5    = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign state_o      = state;

    mem_wait_timer #(
        .MEM_HANDSHAKE (MEM_HANDSHAKE),
        .MEM_LAT       (MEM_LAT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .mem_state (is_mem_state(state)),
        .mem_ready (mem_ready),
        .done      (access_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // R-type operation decode from funct3 / funct7[5].
    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALUCTRL_W'(ALU_ADD);
        unique case (funct3)
            3'b000: r_alu = funct7_b5 ? ALUCTRL_W'(ALU_SUB) : ALUCTRL_W'(ALU_ADD);
            3'b100: r_alu = ALUCTRL_W'(ALU_XOR);
            3'b001: r_alu = ALUCTRL_W'(ALU_SLL);
            3'b101: begin
                if (funct7_b5) r_legal = 1'b0;
                else           r_alu   = ALUCTRL_W'(ALU_SRL);
            end
            3'b111: r_alu = ALUCTRL_W'(ALU_AND);
            3'b110: r_alu = ALUCTRL_W'(ALU_OR);
            3'b010: r_alu = ALUCTRL_W'(ALU_SLT);
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'(WB_ALUOUT);
        alu_src_a  = 2'(SRCA_PC);
        alu_src_b  = 2'(SRCB_RS2);
        alu_ctrl   = ALUCTRL_W'(ALU_ADD);
        pc_source  = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;

        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'(SRCB_FOUR);
                if (access_done) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jal target is precomputed into ALUOut here.
                alu_src_a = 2'(SRCA_OLDPC);
                alu_src_b = 2'(SRCB_IMM);
                unique case (opcode)
                    OPC_OP:               state_next = S_EXEC_R;
                    OPC_OPIMM, OPC_LUI:   state_next = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:  state_next = S_MEM_ADDR;
                    OPC_BRANCH:           state_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OPC_JAL:              state_next = S_JAL;
                    default:              state_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 2'(SRCA_RS1);
                alu_src_b  = 2'(SRCB_RS2);
                alu_ctrl   = r_alu;
                state_next = r_legal ? S_WB_ALU : S_TRAP;
            end
            S_EXEC_I: begin
                alu_src_a  = (opcode == OPC_LUI) ? 2'(SRCA_ZERO) : 2'(SRCA_RS1);
                alu_src_b  = 2'(SRCB_IMM);
                state_next = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 2'(SRCA_RS1);
                alu_src_b  = 2'(SRCB_IMM);
                state_next = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (access_done) state_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (access_done) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                wb_sel     = 2'(WB_MDR);
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                // funct3[0] selects bne (taken on !zero) versus beq (taken on zero).
                alu_src_a  = 2'(SRCA_RS1);
                alu_src_b  = 2'(SRCB_RS2);
                alu_ctrl   = ALUCTRL_W'(ALU_SUB);
                pc_source  = 1'b1;
                pc_write   = ~(zero ^ ~funct3[0]);
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                wb_sel     = 2'(WB_PC);
                pc_write   = 1'b1;
                pc_source  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_next = S_TRAP;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: handshake instance plus a
// fixed-latency (MEM_LAT=3) instance with mem_ready tied low.
module tb_multicycle_control;
    import core_pkg::*;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] ctl;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] instr;
    logic        zero, mem_ready;

    logic       pcw_a, irw_a, iod_a, mr_a, mw_a, rw_a, ps_a, dn_a, tr_a;
    logic [1:0] wb_a, sa_a, sb_a;
    logic [3:0] alu_a, st_a;
    logic       pcw_b, irw_b, iod_b, mr_b, mw_b, rw_b, ps_b, dn_b, tr_b;
    logic [1:0] wb_b, sa_b, sb_b;
    logic [3:0] alu_b, st_b;

    logic [18:0] obs_ctl;
    logic [3:0]  obs_st;
    bit          use_b = 1'b0;

    exp_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string cur     = "";

    logic [18:0] f_wait, f_done, dec, wba, wbm, ma, mrd, mwr, mwr_done, trp, jal_c, ei_add, ei_lui;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_HANDSHAKE(1'b1), .MEM_LAT(1), .ALUCTRL_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_a), .ir_write(irw_a), .i_or_d(iod_a), .mem_read(mr_a),
        .mem_write(mw_a), .reg_write(rw_a), .wb_sel(wb_a), .alu_src_a(sa_a),
        .alu_src_b(sb_a), .alu_ctrl(alu_a), .pc_source(ps_a), .instr_done(dn_a),
        .trap(tr_a), .state_o(st_a)
    );

    multicycle_control #(.MEM_HANDSHAKE(1'b0), .MEM_LAT(3), .ALUCTRL_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .instr(instr), .zero(zero), .mem_ready(1'b0),
        .pc_write(pcw_b), .ir_write(irw_b), .i_or_d(iod_b), .mem_read(mr_b),
        .mem_write(mw_b), .reg_write(rw_b), .wb_sel(wb_b), .alu_src_a(sa_b),
        .alu_src_b(sb_b), .alu_ctrl(alu_b), .pc_source(ps_b), .instr_done(dn_b),
        .trap(tr_b), .state_o(st_b)
    );

    assign obs_st  = use_b ? st_b : st_a;
    assign obs_ctl = use_b ?
        {pcw_b, irw_b, iod_b, mr_b, mw_b, rw_b, wb_b, sa_b, sb_b, alu_b, ps_b, dn_b, tr_b} :
        {pcw_a, irw_a, iod_a, mr_a, mw_a, rw_a, wb_a, sa_a, sb_a, alu_a, ps_a, dn_a, tr_a};

    function automatic logic [18:0] mk(int pcw, int irw, int iod, int mr, int mw, int rw,
                                       int wb, int sa, int sbv, int alu, int ps, int dn, int tr);
        return {1'(pcw), 1'(irw), 1'(iod), 1'(mr), 1'(mw), 1'(rw), 2'(wb), 2'(sa), 2'(sbv),
                4'(alu), 1'(ps), 1'(dn), 1'(tr)};
    endfunction

    function automatic logic [18:0] exec_r(int alu);
        return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, alu, 0, 0, 0);
    endfunction

    function automatic logic [18:0] branch_c(int pcw);
        return mk(pcw, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
    task automatic step(input state_t st, input logic [18:0] c, input logic mr,
                        input logic z, input bit chk = 1'b1);
        exp_t e;
        mem_ready = mr;
        zero      = z;
        sb.push_back('{st: st, ctl: c, chk: chk});
        @(negedge clk);
        if (sb.size() == 0) begin
            check({cur, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({cur, ".state"}, 32'(obs_st), 32'(e.st));
            if (e.chk) check({cur, ".ctl"}, 32'(obs_ctl), 32'(e.ctl));
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r_ins [7];
    int          r_alu [7];
    logic [31:0] bad_ins [2];

    initial begin
        f_wait   = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        f_done   = mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        dec      = mk(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0);
        ei_add   = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        ei_lui   = mk(0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
        wba      = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        wbm      = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        ma       = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        mrd      = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mwr      = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        mwr_done = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        trp      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        jal_c    = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 1, 0);

        r_ins = '{32'h402081B3, 32'h0020C1B3, 32'h002091B3, 32'h0020D1B3,
                  32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3};
        r_alu = '{1, 2, 3, 4, 5, 6, 7};
        bad_ins = '{32'h00000000, 32'h0020C463};

        instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        cur = "reset";
        step(S_FETCH, f_wait, 1'b0, 1'b0);
        rst_a = 1'b0;

        cur = "add"; instr = 32'h002081B3;
        step(S_FETCH, f_done, 1'b1, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_EXEC_R, exec_r(0), 1'b0, 1'b0);
        step(S_WB_ALU, wba, 1'b0, 1'b0);

        cur = "lw"; instr = 32'h0080A283;
        step(S_FETCH, f_done, 1'b1, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_MEM_ADDR, ma, 1'b0, 1'b0);
        step(S_MEM_RD, mrd, 1'b0, 1'b0);
        step(S_MEM_RD, mrd, 1'b0, 1'b0);
        step(S_MEM_RD, mrd, 1'b1, 1'b0);
        step(S_WB_MEM, wbm, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            logic is_bne, zv;
            is_bne = (k < 2);
            zv     = k[0] ? 1'b0 : 1'b1;
            cur    = is_bne ? "bne" : "beq";
            instr  = is_bne ? 32'h00209463 : 32'h00208463;
            step(S_FETCH, f_done, 1'b1, 1'b0);
            step(S_DECODE, dec, 1'b0, 1'b0);
            step(S_BRANCH, branch_c(is_bne ? int'(~zv) : int'(zv)), 1'b0, zv);
        end

        for (int k = 0; k < 7; k++) begin
            cur = $sformatf("rtype%0d", k); instr = r_ins[k];
            step(S_FETCH, f_done, 1'b1, 1'b0);
            step(S_DECODE, dec, 1'b0, 1'b0);
            step(S_EXEC_R, exec_r(r_alu[k]), 1'b0, 1'b0);
            step(S_WB_ALU, wba, 1'b0, 1'b0);
        end

        cur = "addi"; instr = 32'h00500093;
        step(S_FETCH, f_done, 1'b1, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_EXEC_I, ei_add, 1'b0, 1'b0);
        step(S_WB_ALU, wba, 1'b0, 1'b0);

        cur = "lui"; instr = 32'h123450B7;
        step(S_FETCH, f_done, 1'b1, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_EXEC_I, ei_lui, 1'b0, 1'b0);
        step(S_WB_ALU, wba, 1'b0, 1'b0);

        cur = "sw"; instr = 32'h0020A223;
        step(S_FETCH, f_done, 1'b1, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_MEM_ADDR, ma, 1'b0, 1'b0);
        step(S_MEM_WR, mwr_done, 1'b1, 1'b0);

        cur = "jal"; instr = 32'h008000EF;
        step(S_FETCH, f_done, 1'b1, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_JAL, jal_c, 1'b0, 1'b0);

        cur = "sw_rst"; instr = 32'h0020A223;
        step(S_FETCH, f_done, 1'b1, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_MEM_ADDR, ma, 1'b0, 1'b0);
        step(S_MEM_WR, mwr, 1'b0, 1'b0);
        rst_a = 1'b1;
        step(S_MEM_WR, mwr, 1'b0, 1'b0);
        rst_a = 1'b0;
        step(S_FETCH, f_wait, 1'b0, 1'b0);

        cur = "sra"; instr = 32'h4020D1B3;
        step(S_FETCH, f_done, 1'b1, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_EXEC_R, exec_r(0), 1'b0, 1'b0, 1'b0);
        repeat (3) step(S_TRAP, trp, 1'b1, 1'b0);
        rst_a = 1'b1;
        step(S_TRAP, trp, 1'b0, 1'b0);
        rst_a = 1'b0;
        step(S_FETCH, f_wait, 1'b0, 1'b0);

        for (int k = 0; k < 2; k++) begin
            cur = $sformatf("illegal%0d", k); instr = bad_ins[k];
            step(S_FETCH, f_done, 1'b1, 1'b0);
            step(S_DECODE, dec, 1'b0, 1'b0);
            step(S_TRAP, trp, 1'b1, 1'b0);
            rst_a = 1'b1;
            step(S_TRAP, trp, 1'b0, 1'b0);
            rst_a = 1'b0;
        end

        // Fixed-latency instance: every memory state lasts exactly three cycles.
        rst_a = 1'b1;
        use_b = 1'b1;
        cur = "lat_reset";
        step(S_FETCH, f_wait, 1'b0, 1'b0);
        rst_b = 1'b0;

        cur = "lat_sw"; instr = 32'h0020A223;
        step(S_FETCH, f_wait, 1'b1, 1'b0);
        step(S_FETCH, f_wait, 1'b1, 1'b0);
        step(S_FETCH, f_done, 1'b0, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_MEM_ADDR, ma, 1'b0, 1'b0);
        step(S_MEM_WR, mwr, 1'b1, 1'b0);
        step(S_MEM_WR, mwr, 1'b0, 1'b0);
        step(S_MEM_WR, mwr_done, 1'b0, 1'b0);

        cur = "lat_lw"; instr = 32'h0080A283;
        step(S_FETCH, f_wait, 1'b0, 1'b0);
        step(S_FETCH, f_wait, 1'b0, 1'b0);
        step(S_FETCH, f_done, 1'b0, 1'b0);
        step(S_DECODE, dec, 1'b0, 1'b0);
        step(S_MEM_ADDR, ma, 1'b0, 1'b0);
        repeat (3) step(S_MEM_RD, mrd, 1'b0, 1'b0);
        step(S_WB_MEM, wbm, 1'b0, 1'b0);
        step(S_FETCH, f_wait, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
